// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Shares one 8N1 UART transmit line between NREQ byte producers.
//            Round-robin arbitration, one full frame per grant, bit timing
//            from an internal bit-period counter.
// Ports    : clk            - system clock, rising edge
//            reset          - synchronous active-high reset
//            req_valid_i    - per-requester byte pending
//            req_data_i     - byte of requester i at [8*i+7:8*i]
//            req_ready_o    - one-hot accept pulse (combinational)
//            tx_o           - serial line, idle high
//            busy_o         - frame in START/DATA/STOP
//            grant_id_o     - owner of the current/last frame
//            frame_done_o   - pulse on the last clk of the stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
  parameter int NREQ         = 4,
  parameter int CLKS_PER_BIT = 434,
  localparam int GW          = $clog2(NREQ),
  localparam int CW          = $clog2(CLKS_PER_BIT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ*8-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic [GW-1:0]     grant_id_o,
  output logic              frame_done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;

  logic            bit_end;
  logic            arb_cycle;
  logic            found;
  logic [GW-1:0]   pick;
  logic            grant_go;

  assign bit_end = (bit_cnt_q == BIT_LAST);

  // The STOP bit_end cycle doubles as an arbitration cycle so a pending
  // request starts its frame on the very next clock with no idle gap.
  assign arb_cycle = (state_q == S_IDLE) || ((state_q == S_STOP) && bit_end);

  // Round-robin search starting one past the last winner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  assign grant_go    = arb_cycle && found;
  assign req_ready_o = grant_go ? ({{(NREQ-1){1'b0}}, 1'b1} << pick) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rr_ptr_q   <= GW'(NREQ - 1);
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    tx_o       = 1'b1;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
      end
      S_START: begin
        tx_o      = 1'b0;
        bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        tx_o      = shift_q[0];
        bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A grant overrides the normal progression from IDLE or STOP.
    if (grant_go) begin
      state_d    = S_START;
      shift_d    = req_data_i[{pick, 3'b000} +: 8];
      grant_id_d = pick;
      rr_ptr_d   = pick;
      bit_cnt_d  = '0;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = (state_q == S_STOP) && bit_end;
  assign grant_id_o   = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Purpose  : Self-checking bench for uart_tx_scheduler (NREQ=4, 4 clk/bit).
//            A frame-level reference model predicts every output each cycle;
//            directed scenarios add literal expectations on top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

  localparam int NREQ = 4;
  localparam int CPB  = 4;
  localparam int FLEN = 10 * CPB;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx;
  logic              busy;
  logic [1:0]        grant_id;
  logic              frame_done;

  uart_tx_scheduler #(.NREQ(NREQ), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .tx_o         (tx),
    .busy_o       (busy),
    .grant_id_o   (grant_id),
    .frame_done_o (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fd_count = 0;
  int gq[$];
  int cq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: a frame is 40 consecutive cycles whose line value is
  // bit (pos / CPB) of {1, byte, 0}.
  bit        m_ok     = 1'b0;
  bit        m_active = 1'b0;
  int        m_pos    = 0;
  logic [7:0] m_byte  = '0;
  int        m_rr     = NREQ - 1;
  int        m_gid    = 0;

  always @(negedge clk) begin
    int         b;
    logic       e_tx;
    bit         e_arb;
    int         e_pick;
    logic [3:0] e_ready;
    e_tx = 1'b1;
    if (m_active) begin
      b = m_pos / CPB;
      if (b == 0)      e_tx = 1'b0;
      else if (b <= 8) e_tx = m_byte[b-1];
      else             e_tx = 1'b1;
    end
    e_arb  = !m_active || (m_pos == FLEN - 1);
    e_pick = -1;
    if (e_arb) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (e_pick < 0 && req_valid[(m_rr + k) % NREQ]) e_pick = (m_rr + k) % NREQ;
      end
    end
    e_ready = (e_pick >= 0) ? (4'b0001 << e_pick) : 4'b0000;

    if (m_ok) begin
      check("tx", tx, e_tx);
      check("busy", busy, m_active);
      check("frame_done", frame_done, m_active && (m_pos == FLEN - 1));
      check("req_ready", req_ready, e_ready);
      check("grant_id", grant_id, m_gid);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          gq.push_back(i);
          cq.push_back(cyc);
        end
      end
      if (frame_done) fd_count++;
    end

    // Advance the model to the state after the coming rising edge.
    if (reset) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_rr     = NREQ - 1;
      m_gid    = 0;
      m_ok     = 1'b1;
    end else if (e_pick >= 0) begin
      m_active = 1'b1;
      m_pos    = 0;
      m_byte   = req_data[8*e_pick +: 8];
      m_rr     = e_pick;
      m_gid    = e_pick;
    end else if (m_active) begin
      m_pos++;
      if (m_pos == FLEN) m_active = 1'b0;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset     = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    gq.delete();
    cq.delete();
  endtask

  task automatic wait_grants(input int n, input string name);
    int i;
    i = 0;
    while (gq.size() < n && i < 500) begin
      @(posedge clk);
      i++;
    end
    #1;
    if (gq.size() < n) check(name, gq.size(), n);
  endtask

  task automatic check_grants(input string name, input int exp[$]);
    check({name, "_count"}, gq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < gq.size(); i++) check(name, gq[i], exp[i]);
  endtask

  logic [9:0] exp_a5;
  logic       tx_arr [FLEN];
  int         fd_pos;
  int         fd0;

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    exp_a5    = 10'b1101001010;  // bit k = k-th line bit of 0xA5 frame

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_gid", grant_id, 0);

    // 1: single byte 0xA5 from requester 0
    @(posedge clk); #1;
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    @(negedge clk);
    check("t1_ready", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    fd_pos = -1;
    for (int p = 0; p < FLEN; p++) begin
      @(negedge clk);
      tx_arr[p] = tx;
      if (frame_done) fd_pos = p;
    end
    for (int k = 0; k < 10; k++) check("t1_bit", tx_arr[k*CPB + 2], exp_a5[k]);
    check("t1_fd_pos", fd_pos, FLEN - 1);
    @(negedge clk);
    check("t1_idle_busy", busy, 0);

    // 2: round-robin with all four valid, frames back-to-back
    do_reset();
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    wait_grants(5, "t2_timeout");
    req_valid = '0;
    check_grants("t2_grant", '{0, 1, 2, 3, 0});
    for (int i = 1; i < cq.size(); i++) check("t2_gap", cq[i] - cq[i-1], FLEN);
    repeat (45) @(posedge clk);
    #1;

    // 3: fairness after skipping idle requesters
    do_reset();
    req_data  = {8'h33, 8'h22, 8'h11, 8'h00};
    req_valid = 4'b1000;
    wait_grants(1, "t3_timeout_a");
    req_valid = 4'b1010;
    wait_grants(3, "t3_timeout_b");
    req_valid = '0;
    check_grants("t3_grant", '{3, 1, 3});
    repeat (45) @(posedge clk);
    #1;

    // 4: late request waits for the stop bit_end
    do_reset();
    req_data  = {8'h00, 8'hC3, 8'h00, 8'hAA};
    req_valid = 4'b0001;
    wait_grants(1, "t4_timeout_a");
    req_valid = '0;
    repeat (10) @(posedge clk);
    #1;
    req_valid = 4'b0100;
    wait_grants(2, "t4_timeout_b");
    req_valid = '0;
    check_grants("t4_grant", '{0, 2});
    if (cq.size() >= 2) check("t4_gap", cq[1] - cq[0], FLEN);
    @(negedge clk);
    check("t4_start_tx", tx, 0);
    repeat (45) @(posedge clk);
    #1;

    // 5: reset in the middle of DATA bit 3
    do_reset();
    req_data  = {8'h77, 8'h00, 8'h00, 8'h3C};
    req_valid = 4'b0001;
    wait_grants(1, "t5_timeout_a");
    req_valid = '0;
    repeat (17) @(posedge clk);
    #1;
    fd0   = fd_count;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_tx", tx, 1);
    check("t5_busy", busy, 0);
    gq.delete();
    cq.delete();
    @(posedge clk); #1;
    req_valid = 4'b1001;
    wait_grants(2, "t5_timeout_b");
    req_valid = '0;
    check_grants("t5_grant", '{0, 3});
    check("t5_fd_count", fd_count - fd0, 1);
    repeat (45) @(posedge clk);
    #1;

    // 6: withdrawn request is never acknowledged
    do_reset();
    req_data  = {8'h00, 8'h00, 8'h99, 8'h5A};
    req_valid = 4'b0001;
    wait_grants(1, "t6_timeout");
    req_valid = '0;
    repeat (5) @(posedge clk);
    #1;
    req_valid = 4'b0010;
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check_grants("t6_grant", '{0});
    check("t6_tx", tx, 1);
    check("t6_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
